// File: rtl/uart_initiator.sv
// UART initiator: sends one command byte, then waits for and receives one response byte.
// Optional echo compare is enabled by defining UART_INITIATOR_ECHO_CHECK_EN.
module uart_initiator #(
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_x8,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       RsTx,
  input  logic       RsRx,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  output logic       timeout,
  output logic       frame_err,
  output logic       mismatch,
  output logic [1:0] state
);
  // state    | meaning
  // ST_IDLE  | ready for a command, RsTx idle high
  // ST_SEND  | shifting the command frame out on RsTx
  // ST_WAIT  | counting ticks until a response start bit or timeout
  // ST_RECV  | sampling the response frame mid-bit
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_WAIT = 2'd2, ST_RECV = 2'd3} state_e;

  localparam int TO_LIMIT = TIMEOUT_BITS * 8;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  state_e          state_q, state_d;
  logic [2:0]      tick_cnt_q, tick_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            tx_q, tx_d;
  logic            sync1_q, sync2_q;
  logic            rsp_valid_q, rsp_valid_d;
  logic            timeout_q, timeout_d;
  logic            frame_err_q, frame_err_d;
  logic            ev_done, ev_timeout, ev_ferr;
  logic [9:0]      tx_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      tx_byte_q   <= '0;
      rx_sh_q     <= '0;
      rsp_data_q  <= '0;
      tx_q        <= 1'b1;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      tx_byte_q   <= tx_byte_d;
      rx_sh_q     <= rx_sh_d;
      rsp_data_q  <= rsp_data_d;
      tx_q        <= tx_d;
      sync1_q     <= RsRx;
      sync2_q     <= sync1_q;
      rsp_valid_q <= rsp_valid_d;
      timeout_q   <= timeout_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign to_cnt_inc = to_cnt_q + TO_W'(1);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    tx_byte_d  = tx_byte_q;
    rx_sh_d    = rx_sh_q;
    rsp_data_d = rsp_data_q;
    ev_done    = 1'b0;
    ev_timeout = 1'b0;
    ev_ferr    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d    = ST_SEND;
          tx_byte_d  = cmd_data;
          tick_cnt_d = 3'd7;
          bit_cnt_d  = 4'd0;
        end
      end
      ST_SEND: begin
        if (tick_x8) begin
          if (tick_cnt_q != 3'd0) begin
            tick_cnt_d = tick_cnt_q - 3'd1;
          end else begin
            tick_cnt_d = 3'd7;
            if (bit_cnt_q == 4'd9) begin
              state_d  = ST_WAIT;
              to_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end
      ST_WAIT: begin
        // a start bit on the same tick as expiry wins over the timeout
        if (tick_x8) begin
          if (!sync2_q) begin
            state_d    = ST_RECV;
            tick_cnt_d = 3'd3;
            bit_cnt_d  = 4'd0;
          end else if (to_cnt_inc == TO_W'(TO_LIMIT)) begin
            state_d    = ST_IDLE;
            to_cnt_d   = '0;
            ev_timeout = 1'b1;
          end else begin
            to_cnt_d = to_cnt_inc;
          end
        end
      end
      ST_RECV: begin
        if (tick_x8) begin
          if (tick_cnt_q != 3'd0) begin
            tick_cnt_d = tick_cnt_q - 3'd1;
          end else begin
            tick_cnt_d = 3'd7;
            if (bit_cnt_q == 4'd0) begin
              // start bit gone high mid-bit: treat as a glitch, keep timeout progress
              if (sync2_q) state_d = ST_WAIT;
              else         bit_cnt_d = 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
              state_d = ST_IDLE;
              if (sync2_q) begin
                rsp_data_d = rx_sh_q;
                ev_done    = 1'b1;
              end else begin
                ev_ferr = 1'b1;
              end
            end else begin
              rx_sh_d   = {sync2_q, rx_sh_q[7:1]};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_frame = {1'b1, tx_byte_d, 1'b0};

  always_comb begin
    rsp_valid_d = ev_done;
    timeout_d   = ev_timeout;
    frame_err_d = ev_ferr;
    tx_d        = 1'b1;
    if (state_d == ST_SEND) tx_d = tx_frame[bit_cnt_d];
  end

`ifdef UART_INITIATOR_ECHO_CHECK_EN
  logic mismatch_q;
  always_ff @(posedge clk) begin
    if (rst) mismatch_q <= 1'b0;
    else     mismatch_q <= ev_done && (rx_sh_q != tx_byte_q);
  end
  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign RsTx      = tx_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign timeout   = timeout_q;
  assign frame_err = frame_err_q;
  assign state     = state_q;
endmodule

// File: tb/tb_uart_initiator.sv
// Directed bench for uart_initiator: command framing, echo receive, timeout,
// start-glitch rejection, framing error and mid-frame reset.
module tb_uart_initiator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_x8 = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       RsTx;
  logic       RsRx = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       timeout;
  logic       frame_err;
  logic       mismatch;
  logic [1:0] state;

  uart_initiator #(.TIMEOUT_BITS(40)) dut (
    .clk(clk), .rst(rst), .tick_x8(tick_x8),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .RsTx(RsTx), .RsRx(RsRx),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .timeout(timeout),
    .frame_err(frame_err), .mismatch(mismatch), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_to = 0;
  int n_fe = 0;
  int n_multi = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_mis = 1'b0;
  logic       exp_mis;
  logic [7:0] cap;

`ifdef UART_INITIATOR_ECHO_CHECK_EN
  initial exp_mis = 1'b1;
`else
  initial exp_mis = 1'b0;
`endif

  // pulse monitor; status pulses are one cycle wide so one negedge sees each
  always @(negedge clk) begin
    if (rsp_valid) begin
      n_valid++;
      last_data = rsp_data;
      last_mis  = mismatch;
    end
    if (timeout) n_to++;
    if (frame_err) n_fe++;
    if ((32'(rsp_valid) + 32'(timeout) + 32'(frame_err)) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    repeat (3) @(negedge clk);
    tick_x8 = 1'b1;
    @(negedge clk);
    tick_x8 = 1'b0;
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
  endtask

  // ticks through the full command frame, checking each bit mid-period
  task automatic tx_frame(input logic [7:0] b, output logic [7:0] c);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    c = 8'h00;
    for (int i = 0; i < 10; i++) begin
      for (int t = 0; t < 8; t++) begin
        do_tick();
        if (t == 3) begin
          check($sformatf("tx_bit%0d", i), 32'(RsTx), 32'(fr[i]));
          if (i >= 1 && i <= 8) c[i-1] = RsTx;
        end
        if (i == 9 && t == 6) check("send_79_ticks", 32'(state), 32'd1);
      end
    end
    check("wait_after_80", 32'(state), 32'd2);
  endtask

  task automatic rsp_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RsRx = fr[i];
      repeat (8) do_tick();
    end
    RsRx = 1'b1;
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_tx", 32'(RsTx), 32'd1);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_data", 32'(rsp_data), 32'h00);
    check("rst_pulses", {28'd0, rsp_valid, timeout, frame_err, mismatch}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // RX activity in IDLE is ignored
    RsRx = 1'b0;
    repeat (16) do_tick();
    check("idle_ignore_state", 32'(state), 32'd0);
    check("idle_ignore_ready", 32'(cmd_ready), 32'd1);
    RsRx = 1'b1;
    repeat (4) do_tick();

    // 0xA5 echoed back
    send_cmd(8'hA5);
    check("accept_state", 32'(state), 32'd1);
    check("accept_ready", 32'(cmd_ready), 32'd0);
    check("accept_tx_start", 32'(RsTx), 32'd0);
    repeat (20) @(negedge clk);
    #1;
    check("no_tick_hold", {30'd0, state}, 32'd1);
    tx_frame(8'hA5, cap);
    check("captured_a5", 32'(cap), 32'hA5);
    rsp_frame(cap, 1'b1);
    check("a5_valid_cnt", n_valid, 32'd1);
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_mismatch", 32'(last_mis), 32'd0);
    check("a5_state", 32'(state), 32'd0);

    // 0x3C answered with 0x3D
    send_cmd(8'h3C);
    tx_frame(8'h3C, cap);
    rsp_frame(8'h3D, 1'b1);
    check("3d_valid_cnt", n_valid, 32'd2);
    check("3d_data", 32'(rsp_data), 32'h3D);
    check("3d_mismatch", 32'(last_mis), 32'(exp_mis));

    // no response: timeout exactly 320 ticks after WAIT entry
    send_cmd(8'h00);
    tx_frame(8'h00, cap);
    repeat (319) do_tick();
    check("to_not_yet", n_to, 32'd0);
    check("to_still_wait", 32'(state), 32'd2);
    do_tick();
    check("to_fired", n_to, 32'd1);
    check("to_state_idle", 32'(state), 32'd0);
    check("to_no_valid", n_valid, 32'd2);

    // start-bit glitch in WAIT, then a good 0x55
    send_cmd(8'h55);
    tx_frame(8'h55, cap);
    repeat (5) do_tick();
    RsRx = 1'b0;
    repeat (2) do_tick();
    RsRx = 1'b1;
    repeat (6) do_tick();
    check("glitch_state", 32'(state), 32'd2);
    check("glitch_no_pulse", n_valid + n_fe, 32'd2);
    rsp_frame(8'h55, 1'b1);
    check("55_valid_cnt", n_valid, 32'd3);
    check("55_data", 32'(rsp_data), 32'h55);
    check("55_mismatch", 32'(last_mis), 32'd0);

    // framing error keeps old rsp_data
    send_cmd(8'h81);
    tx_frame(8'h81, cap);
    rsp_frame(8'h81, 1'b0);
    check("fe_cnt", n_fe, 32'd1);
    check("fe_no_valid", n_valid, 32'd3);
    check("fe_data_kept", 32'(rsp_data), 32'h55);
    check("fe_state", 32'(state), 32'd0);

    // reset during data bit 3 (0xF0 has bit 3 = 0)
    send_cmd(8'hF0);
    repeat (35) do_tick();
    check("pre_rst_tx_bit3", 32'(RsTx), 32'd0);
    check("pre_rst_state", 32'(state), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_tx", 32'(RsTx), 32'd1);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    repeat (100) do_tick();
    check("post_rst_pulses", n_valid + n_to + n_fe, 32'd5);
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_tx", 32'(RsTx), 32'd1);

    check("pulses_exclusive", n_multi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
